// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display: segment codes, digit positions
// and the binary-to-decimal digit helpers.
package stopwatch_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [1:0] DIGIT_SEC_ONES = 2'd0;
   localparam logic [1:0] DIGIT_SEC_TENS = 2'd1;
   localparam logic [1:0] DIGIT_MIN_ONES = 2'd2;
   localparam logic [1:0] DIGIT_MIN_TENS = 2'd3;

   localparam logic [5:0] MAX_VAL = 6'd59;

   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd11;

   // Out-of-range values render as dashes on both digits of the pair.
   function automatic logic [3:0] tensCode(input logic [5:0] v);
      logic [5:0] q;
      q = v / 6'd10;
      return (v > MAX_VAL) ? CODE_DASH : q[3:0];
   endfunction

   function automatic logic [3:0] onesCode(input logic [5:0] v);
      logic [5:0] r;
      r = v % 6'd10;
      return (v > MAX_VAL) ? CODE_DASH : r[3:0];
   endfunction

endpackage

// File: rtl/stopwatch_seg_decode.sv
// Digit code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Codes 0-9 are decimal digits, 10 is a dash, anything else is blank.
module stopwatch_seg_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] segs
);

   always_comb begin
      segs = SEG_BLANK;
      case (code)
         4'd0:      segs = SEG_0;
         4'd1:      segs = SEG_1;
         4'd2:      segs = SEG_2;
         4'd3:      segs = SEG_3;
         4'd4:      segs = SEG_4;
         4'd5:      segs = SEG_5;
         4'd6:      segs = SEG_6;
         4'd7:      segs = SEG_7;
         4'd8:      segs = SEG_8;
         4'd9:      segs = SEG_9;
         CODE_DASH: segs = SEG_DASH;
         default:   segs = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed MM.SS display: frame-aligned snapshot of the time,
// digit scan, adjust-mode blinking and registered anode/segment outputs.
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       btnR,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       swADJ,
   input  logic       swSEL,
   output logic [3:0] an,
   output logic [7:0] seg
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0]  SCAN_ONE   = SCAN_W'(1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

   logic [SCAN_W-1:0]  scanCnt;
   logic [1:0]         digitIdx;
   logic [BLINK_W-1:0] blinkCnt;
   logic               blinkOn;
   logic [5:0]         snapMin;
   logic [5:0]         snapSec;

   logic scanTick;
   logic frameTick;
   assign scanTick  = (scanCnt == SCAN_LAST);
   assign frameTick = scanTick && (digitIdx == DIGIT_MIN_TENS);

   always_ff @(posedge clk or posedge btnR) begin
      if (btnR) begin
         scanCnt  <= '0;
         digitIdx <= DIGIT_SEC_ONES;
      end else if (scanTick) begin
         scanCnt  <= '0;
         digitIdx <= digitIdx + 2'd1;
      end else begin
         scanCnt  <= scanCnt + SCAN_ONE;
      end
   end

   // Blink phase only runs in adjust mode; leaving adjust restarts it lit.
   always_ff @(posedge clk or posedge btnR) begin
      if (btnR) begin
         blinkCnt <= '0;
         blinkOn  <= 1'b1;
      end else if (!swADJ) begin
         blinkCnt <= '0;
         blinkOn  <= 1'b1;
      end else if (blinkCnt == BLINK_LAST) begin
         blinkCnt <= '0;
         blinkOn  <= ~blinkOn;
      end else begin
         blinkCnt <= blinkCnt + BLINK_ONE;
      end
   end

   // Loading only at the frame boundary keeps all four digits consistent.
   always_ff @(posedge clk or posedge btnR) begin
      if (btnR) begin
         snapMin <= '0;
         snapSec <= '0;
      end else if (frameTick) begin
         snapMin <= minutes;
         snapSec <= seconds;
      end
   end

   logic [5:0] pairVal;
   logic       blankNow;
   logic [3:0] digitCode;
   logic       dpNext;
   logic [6:0] segNext;

   always_comb begin
      pairVal   = digitIdx[1] ? snapMin : snapSec;
      blankNow  = swADJ && !blinkOn && (swSEL ? !digitIdx[1] : digitIdx[1]);
      digitCode = digitIdx[0] ? tensCode(pairVal) : onesCode(pairVal);
      if (blankNow) begin
         digitCode = CODE_BLANK;
      end
      dpNext = !((digitIdx == DIGIT_MIN_ONES) && !blankNow);
   end

   stopwatch_seg_decode uDecode (
      .code (digitCode),
      .segs (segNext)
   );

   always_ff @(posedge clk or posedge btnR) begin
      if (btnR) begin
         an  <= 4'b1110;
         seg <= 8'hC0;
      end else begin
         an  <= ~(4'b0001 << digitIdx);
         seg <= {dpNext, segNext};
      end
   end

endmodule
